// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch block.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/lap_stopwatch_if.sv
// Lap drain port: FIFO head, flags and consumer ready.
interface lap_stopwatch_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] lap_data;
  logic                  lap_valid;
  logic                  lap_ready;
  logic                  lap_full;
  logic                  lap_overflow;

  modport master (
    output lap_data, lap_valid, lap_full, lap_overflow,
    input  lap_ready
  );

  modport slave (
    input  lap_data, lap_valid, lap_full, lap_overflow,
    output lap_ready
  );
endinterface

// File: rtl/lap_fifo.sv
// Synchronous FIFO for captured lap times with flush; head reads as 0 when empty.
module lap_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(LAP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch with prescaler, pause/resume and lap FIFO.
// Define LAP_STOPWATCH_DOWN_EN to make dir select down-counting per step.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int PRESCALE   = 1,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  dir,
  input  logic                  lap,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  lap_stopwatch_if.master       lap_port
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] HOLD = ST_HOLD;

  localparam int                  PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DATA_WIDTH-1:0] CMAX  = DATA_WIDTH'(MAX);

  logic [1:0]            state;
  logic [PW-1:0]         presc;
  logic                  step;
  logic                  will_wrap;
  logic [DATA_WIDTH-1:0] next_count;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow;

  // stop and clear both pre-empt a step that would otherwise land on this edge.
  assign step = (state == RUN) && !clear && !stop && (presc == PS_LAST);

  always_comb begin
    will_wrap  = (count == CMAX);
    next_count = will_wrap ? '0 : count + DATA_WIDTH'(1);
`ifdef LAP_STOPWATCH_DOWN_EN
    if (dir == DIR_DOWN) begin
      will_wrap  = (count == '0);
      next_count = will_wrap ? CMAX : count - DATA_WIDTH'(1);
    end
`endif
  end

`ifndef LAP_STOPWATCH_DOWN_EN
  logic unused_dir;
  assign unused_dir = dir;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= step && will_wrap;
      if (clear) begin
        state <= IDLE;
        presc <= '0;
        count <= '0;
      end else if (stop) begin
        if (state == RUN) state <= HOLD;
        presc <= '0;
      end else if (start && (state != RUN)) begin
        state <= RUN;
        presc <= '0;
      end else if (state == RUN) begin
        presc <= (presc == PS_LAST) ? '0 : presc + PW'(1);
        if (step) count <= next_count;
      end
    end
  end

  assign running = (state == RUN);

  // Laps coinciding with clear are discarded silently; only a genuine full drop is sticky.
  assign pop = lap_port.lap_valid && lap_port.lap_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overflow <= 1'b0;
    else if (clear)                          overflow <= 1'b0;
    else if (lap && fifo_full && !pop)       overflow <= 1'b1;
  end

  lap_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAP_DEPTH  (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (lap && !clear),
    .pop   (pop),
    .din   (count),
    .dout  (lap_port.lap_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign lap_port.lap_valid    = !fifo_empty;
  assign lap_port.lap_full     = fifo_full;
  assign lap_port.lap_overflow = overflow;
endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised stopwatch timer with programmable tick prescaler, pause/resume, optional down-count mode and a lap-capture FIFO. It generalises the team's single-counter stopwatch into a reusable timing block for control/status subsystems. Software or a host FSM drains captured lap times through a valid/ready port.

## Interface
- DATA_WIDTH, 16: width of count and lap entries.
- MAX, 99: terminal count; legal range 1 .. 2**DATA_WIDTH-1.
- PRESCALE, 1: clock cycles per count step; must be ≥1.
- LAP_DEPTH, 4: lap FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin or resume counting (pulse or level).
- stop  in  1  pause counting and hold count.
- clear  in  1  synchronous: count to 0, return to IDLE, flush lap FIFO, clear overflow.
- dir  in  1  0 = count up, 1 = count down; honoured only with the configuration macro defined.
- lap  in  1  capture current count into lap FIFO.
- count  out  DATA_WIDTH  current count.
- running  out  1  high in RUN.
- wrap  out  1  one-cycle pulse on the cycle after a wrap step.
- lap_data  out  DATA_WIDTH  FIFO head.
- lap_valid  out  1  FIFO not empty.
- lap_ready  in  1  consumer accepts head when lap_valid && lap_ready.
- lap_full  out  1  FIFO holds LAP_DEPTH entries.
- lap_overflow  out  1  sticky: a lap was dropped.

## Operation
- States: IDLE (count 0, stopped), RUN, HOLD (stopped, count retained).
- Priority per cycle: clear > stop > start. IDLE/HOLD + start → RUN; RUN + stop → HOLD; any + clear → IDLE. start in RUN is ignored (prescaler not restarted).
- Prescaler: 0..PRESCALE-1 counter, advances only in RUN; a step occurs when it equals PRESCALE-1, then it returns to 0. Entering RUN zeroes it. HOLD freezes it at 0.
- Up step: count == MAX → 0 and wrap; else count+1. Down step: count == 0 → MAX and wrap; else count-1.
- Count never exceeds MAX; arithmetic is DATA_WIDTH bits, no saturation.
- Lap: pushes the count value present during that cycle (pre-update). Push while full and no simultaneous pop → dropped, lap_overflow set. Full with simultaneous pop → push accepted. Lap in the same cycle as clear → dropped, no overflow.
- Pop: lap_valid && lap_ready removes head; lap_data shows the next entry the following cycle.
- stop, start, lap independent: lap is accepted in any state.

## Timing
- Reset values: count 0, running 0, wrap 0, lap_valid 0, lap_full 0, lap_overflow 0, lap_data 0, state IDLE.
- start sampled at edge E: running high after E; first step at edge E+PRESCALE.
- stop sampled at edge E: the step due at E does not occur; running low after E.
- wrap asserted for exactly the cycle following the wrapping edge.
- Lap push at edge E: lap_valid high after E (empty→non-empty latency 1).
- clear or reset mid-run: immediate on that edge (reset asynchronously), no wrap pulse.

## Configuration
- LAP_STOPWATCH_DOWN_EN: when defined, dir selects up/down per step (dir sampled each step). When undefined, dir is ignored, block counts up only, down logic not synthesised.

## Structure
- lap_stopwatch_pkg: state enum typedef (IDLE, RUN, HOLD), direction constants.
- Sub-module lap_fifo: parametrised synchronous FIFO (DATA_WIDTH, LAP_DEPTH) with push/pop, full/empty; overflow flag kept in the top level.

## Test plan
- PRESCALE=1, MAX=99: start pulse at E, count 1 at E+1, 99 at E+99, 0 with wrap pulse at E+100.
- PRESCALE=3: start, stop after 7 cycles → count 2 held in HOLD; start → resumes, count 3 three cycles later.
- start and stop asserted together in IDLE → stays IDLE, count 0; clear with stop and start in RUN at count 40 → IDLE, count 0.
- LAP_DEPTH=4, lap_ready=0: laps at counts 5,6,7,8,9 → lap_full, lap_overflow=1, entries 5..8; drain with lap_ready=1 yields 5,6,7,8 then lap_valid=0.
- Macro defined, dir=1, MAX=9: start from count 0 → 9 with wrap, then 8,7; macro undefined same stimulus → 1,2,3.
- Assert reset mid-run at count 50 with FIFO non-empty → all outputs to reset values without waiting for clk.
